// File: rtl/eth_decap_mux.sv
// Strips Ethernet/IPv4/UDP headers from a 64-bit ingress stream and steers the
// UDP payload to one of NUM_CH output channels selected by destination port.
module eth_decap_mux #(
  parameter int                   NUM_CH        = 4,
  parameter logic [16*NUM_CH-1:0] CH_PORT_VALUE = {NUM_CH{16'h3000}},
  parameter logic [16*NUM_CH-1:0] CH_PORT_MASK  = {NUM_CH{16'hF000}},
  parameter logic [31:0]          IP_LOCAL      = 32'hC0A8_0A01,
  parameter logic [31:0]          IP_PEER       = 32'hC0A8_0A03,
  parameter bit                   CHECK_PEER    = 1'b1
) (
  input  logic              eth_clk,
  input  logic              eth_rst_n,
  input  logic              eth_tvalid,
  input  logic              eth_tlast,
  input  logic [7:0]        eth_tkeep,
  input  logic [63:0]       eth_tdata,
  output logic [NUM_CH-1:0] m_tvalid,
  input  logic [NUM_CH-1:0] m_tready,
  output logic [63:0]       m_tdata,
  output logic [7:0]        m_tkeep,
  output logic              m_tlast,
  output logic              m_tuser,
  output logic [15:0]       cnt_ok,
  output logic [15:0]       cnt_filter,
  output logic [15:0]       cnt_trunc,
  output logic [15:0]       cnt_busy
);

  // State name = which ingress beat is expected next.
  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_HDR1    = 4'd1;
  localparam logic [3:0] S_HDR2    = 4'd2;
  localparam logic [3:0] S_HDR3    = 4'd3;
  localparam logic [3:0] S_HDR4    = 4'd4;
  localparam logic [3:0] S_HDR5    = 4'd5;
  localparam logic [3:0] S_PAYLOAD = 4'd6;
  localparam logic [3:0] S_FLUSH   = 4'd7;
  localparam logic [3:0] S_TRUNC   = 4'd8;
  localparam logic [3:0] S_DISCARD = 4'd9;

  logic [3:0]        state;
  logic [47:0]       hold;
  logic [7:0]        flush_keep;
  logic [2:0]        ch;
  logic              tlast_seen;
  logic              skip;

  logic [3:0]        keep_cnt;
  logic              slot_free;
  logic [15:0]       dport;
  logic [31:0]       saddr;
  logic              port_hit;
  logic [2:0]        port_ch;
  logic              hdr_ok;
  logic              busy_hit;
  logic              skip_nxt;
  logic [NUM_CH-1:0] ch_bit;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] keep_mask(input logic [3:0] n);
    logic [8:0] t;
    t = (9'd1 << n) - 9'd1;
    return t[7:0];
  endfunction

  assign ch_bit    = NUM_CH'(1) << ch;
  assign slot_free = (m_tvalid == '0) || ((m_tvalid & m_tready) != '0);
  assign dport     = {eth_tdata[39:32], eth_tdata[47:40]};
  assign saddr     = {eth_tdata[23:16], eth_tdata[31:24], eth_tdata[39:32], eth_tdata[47:40]};

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    keep_cnt = '0;
    port_hit = 1'b0;
    port_ch  = '0;
    hdr_ok   = 1'b1;
    busy_hit = 1'b0;
    skip_nxt = skip;
    for (int i = 0; i < 8; i++) keep_cnt = keep_cnt + {3'b000, eth_tkeep[i]};
    // Scan downwards so the lowest matching channel wins.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if ((dport & CH_PORT_MASK[16*i +: 16]) == CH_PORT_VALUE[16*i +: 16]) begin
        port_hit = 1'b1;
        port_ch  = 3'(i);
      end
    end
    case (state)
      S_HDR1:  hdr_ok = (eth_tdata[47:32] == 16'h0008) && (eth_tdata[55:48] == 8'h45);
      S_HDR2:  hdr_ok = (eth_tdata[63:56] == 8'd17);
      S_HDR3:  hdr_ok = (!CHECK_PEER || (saddr == IP_PEER)) &&
                        ({eth_tdata[55:48], eth_tdata[63:56]} == IP_LOCAL[31:16]);
      S_HDR4:  hdr_ok = ({eth_tdata[7:0], eth_tdata[15:8]} == IP_LOCAL[15:0]) && port_hit;
      default: hdr_ok = 1'b1;
    endcase
    // A beat arriving after the frame ended but before its tail left is the next frame's beat0.
    if (eth_tvalid && (state == S_FLUSH || (state == S_TRUNC && tlast_seen))) begin
      busy_hit = !skip;
      skip_nxt = !eth_tlast;
    end
  end

  always_ff @(posedge eth_clk) begin
    if (!eth_rst_n) begin
      state      <= S_IDLE;
      hold       <= '0;
      flush_keep <= '0;
      ch         <= '0;
      tlast_seen <= 1'b0;
      skip       <= 1'b0;
      m_tvalid   <= '0;
      m_tdata    <= '0;
      m_tkeep    <= '0;
      m_tlast    <= 1'b0;
      m_tuser    <= 1'b0;
      cnt_ok     <= '0;
      cnt_filter <= '0;
      cnt_trunc  <= '0;
      cnt_busy   <= '0;
    end else begin
      // NOTE: nonblocking assignments later in this block override this default clear.
      if ((m_tvalid & m_tready) != '0) begin
        m_tvalid <= '0;
        m_tdata  <= '0;
        m_tkeep  <= '0;
        m_tlast  <= 1'b0;
        m_tuser  <= 1'b0;
      end
      case (state)
        S_IDLE: if (eth_tvalid) begin
          if (!slot_free) begin
            cnt_busy <= sat_inc(cnt_busy);
            state    <= eth_tlast ? S_IDLE : S_DISCARD;
          end else if (eth_tlast) begin
            cnt_filter <= sat_inc(cnt_filter);
          end else begin
            state <= S_HDR1;
          end
        end
        S_HDR1, S_HDR2, S_HDR3, S_HDR4: if (eth_tvalid) begin
          if (!hdr_ok || eth_tlast) begin
            cnt_filter <= sat_inc(cnt_filter);
            state      <= eth_tlast ? S_IDLE : S_DISCARD;
          end else begin
            state <= state + 4'd1;
          end
          if (state == S_HDR4) ch <= port_ch;
        end
        S_HDR5: if (eth_tvalid) begin
          hold <= eth_tdata[63:16];
          if (!eth_tlast) begin
            state <= S_PAYLOAD;
          end else if (keep_cnt <= 4'd2) begin
            cnt_filter <= sat_inc(cnt_filter);
            state      <= S_IDLE;
          end else if (!slot_free) begin
            m_tdata    <= '0;
            m_tkeep    <= '0;
            m_tlast    <= 1'b1;
            m_tuser    <= 1'b1;
            cnt_trunc  <= sat_inc(cnt_trunc);
            tlast_seen <= 1'b1;
            state      <= S_TRUNC;
          end else begin
            m_tvalid <= ch_bit;
            m_tdata  <= {16'h0000, eth_tdata[63:16]};
            m_tkeep  <= keep_mask(keep_cnt - 4'd2);
            m_tlast  <= 1'b1;
            m_tuser  <= 1'b0;
            cnt_ok   <= sat_inc(cnt_ok);
            state    <= S_IDLE;
          end
        end
        S_PAYLOAD: if (eth_tvalid) begin
          hold <= eth_tdata[63:16];
          if (!slot_free) begin
            // Consumer fell behind: the stalled beat becomes a truncation marker.
            m_tdata    <= '0;
            m_tkeep    <= '0;
            m_tlast    <= 1'b1;
            m_tuser    <= 1'b1;
            cnt_trunc  <= sat_inc(cnt_trunc);
            tlast_seen <= eth_tlast;
            state      <= S_TRUNC;
          end else begin
            m_tvalid <= ch_bit;
            m_tdata  <= {eth_tdata[15:0], hold};
            m_tuser  <= 1'b0;
            if (eth_tlast && keep_cnt <= 4'd2) begin
              m_tkeep <= keep_mask(4'd6 + keep_cnt);
              m_tlast <= 1'b1;
              cnt_ok  <= sat_inc(cnt_ok);
              state   <= S_IDLE;
            end else begin
              m_tkeep <= 8'hFF;
              m_tlast <= 1'b0;
              if (eth_tlast) begin
                flush_keep <= keep_mask(keep_cnt - 4'd2);
                state      <= S_FLUSH;
              end
            end
          end
        end
        S_FLUSH: begin
          if (busy_hit) cnt_busy <= sat_inc(cnt_busy);
          skip <= skip_nxt;
          if (slot_free) begin
            m_tvalid <= ch_bit;
            m_tdata  <= {16'h0000, hold};
            m_tkeep  <= flush_keep;
            m_tlast  <= 1'b1;
            m_tuser  <= 1'b0;
            cnt_ok   <= sat_inc(cnt_ok);
            skip     <= 1'b0;
            state    <= skip_nxt ? S_DISCARD : S_IDLE;
          end
        end
        S_TRUNC: begin
          if (busy_hit) cnt_busy <= sat_inc(cnt_busy);
          skip <= skip_nxt;
          if (eth_tvalid && eth_tlast) tlast_seen <= 1'b1;
          if (slot_free && (tlast_seen || (eth_tvalid && eth_tlast))) begin
            skip       <= 1'b0;
            tlast_seen <= 1'b0;
            state      <= skip_nxt ? S_DISCARD : S_IDLE;
          end
        end
        S_DISCARD: if (eth_tvalid && eth_tlast) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
